// File: rtl/ser2par_frame_assembler.sv
// ser2par_frame_assembler
//   Packs DEPTH consecutive WIDTH-bit words from a valid/ready stream into one
//   parallel frame held in a registered output slot. Full frames stream
//   back-to-back with no bubble. A level flush emits a partially assembled
//   frame together with its word count.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_data    input word
//   in_valid   in_data valid
//   in_ready   word can be taken this cycle (combinational, depends on out_ready)
//   flush      level request to emit the partially assembled frame
//   out_frame  assembled frame (registered)
//   out_valid  out_frame/out_count valid (registered)
//   out_ready  consumer takes the frame this cycle
//   out_count  number of valid words in out_frame, 1..DEPTH (registered)
module ser2par_frame_assembler #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 4,
  parameter bit FIRST_IN_LOW = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       flush,
  output logic [WIDTH*DEPTH-1:0]     out_frame,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] out_count
);

  localparam int FW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [FW-1:0]                 fill_cnt;
  logic [DEPTH-1:0][WIDTH-1:0]   asm_q;
  logic [DEPTH-1:0][WIDTH-1:0]   merged;
  logic [DEPTH-1:0]              hit;
  logic                          slot_free, last, accept, drain;
  logic                          full_emit, flush_emit, emit;
  logic [CW-1:0]                 count_next;

  assign slot_free = !out_valid | out_ready;
  assign last      = (fill_cnt == FW'(DEPTH-1));
  // The closing word needs somewhere to go, so it waits for the output slot.
  assign in_ready  = !last | slot_free;
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  // A flush coinciding with the closing word is just the normal full emit.
  assign full_emit  = accept & last;
  assign flush_emit = flush & slot_free & ((fill_cnt != '0) | accept) & !full_emit;
  assign emit       = full_emit | flush_emit;

  assign count_next = CW'(fill_cnt) + CW'(accept);

  // Per-slot steering: slot i receives word index J of the frame.
  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_slot
      localparam int J = FIRST_IN_LOW ? i : DEPTH-1-i;
      assign hit[i]    = accept && (fill_cnt == FW'(J));
      assign merged[i] = hit[i] ? in_data : asm_q[i];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_cnt  <= '0;
      asm_q     <= '0;
      out_frame <= '0;
      out_valid <= 1'b0;
      out_count <= '0;
    end else if (emit) begin
      // Buffered words plus this cycle's word; untouched slots are zero
      // because the buffer is cleared after every emit.
      out_frame <= merged;
      out_count <= count_next;
      out_valid <= 1'b1;
      fill_cnt  <= '0;
      asm_q     <= '0;
    end else begin
      if (accept) begin
        asm_q    <= merged;
        fill_cnt <= fill_cnt + FW'(1);
      end
      // Frame and count keep their old values after a drain.
      if (drain) out_valid <= 1'b0;
    end
  end

endmodule
